// File: rtl/gf_mix_columns_seq_if.sv
// ---------------------------------------------------------------------------
// gf_mix_columns_seq_if
//
// Purpose: groups the upstream and downstream valid/ready handshakes of the
// sequential GF(2^8) column mixer into one bundle.
//
// Parameters:
//   NCOL      number of 32-bit columns per block (1..8)
//
// Signals:
//   in_valid  upstream presents a block on data_in/mode
//   in_ready  mixer can accept a block (IDLE only)
//   mode      0 = MixColumns, 1 = InvMixColumns; sampled on accept
//   data_in   input block, column 0 in the MSB 32 bits
//   out_valid data_out holds a complete result
//   out_ready downstream accepts the result
//   data_out  result block, same packing as data_in
//   busy      mixer is in RUN or DONE
//
// Modports:
//   master    producer/consumer side (drives inputs, observes outputs)
//   slave     mixer side
// ---------------------------------------------------------------------------
interface gf_mix_columns_seq_if #(
  parameter int NCOL = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 mode;
  logic [32*NCOL-1:0]   data_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [32*NCOL-1:0]   data_out;
  logic                 busy;

  modport master (
    output in_valid,
    output mode,
    output data_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  data_out,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  mode,
    input  data_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output data_out,
    output busy
  );
endinterface

// File: rtl/gf_mix_columns_seq.sv
// ---------------------------------------------------------------------------
// gf_mix_columns_seq
//
// Purpose: sequential AES MixColumns / InvMixColumns over a block of NCOL
// 32-bit columns, one column per clock. Sits between ShiftRows and
// AddRoundKey. All GF(2^8) products are built from a parametrised xtime
// (multiply-by-2) primitive; no multipliers or lookup tables.
//
// Parameters:
//   NCOL   columns per block, legal range 1..8
//   POLY   low 8 bits of the reduction polynomial used by xtime
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   abort  (only with GF_MIX_ABORT_EN) discard the block in RUN/DONE
//   bus    gf_mix_columns_seq_if.slave handshake bundle
//
// Optional feature macro: GF_MIX_ABORT_EN
//   Defined   : adds the abort input; abort in RUN or DONE returns to IDLE,
//               clears data_out and col_cnt, and wins over out_ready.
//   Undefined : no abort port; every accepted block runs to completion.
//
// Timing: accept edge is cycle 0, out_valid rises after exactly NCOL edges.
// With out_ready held high one block is processed every NCOL+2 cycles.
// ---------------------------------------------------------------------------
module gf_mix_columns_seq #(
  parameter int         NCOL = 4,
  parameter logic [7:0] POLY = 8'h1b
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef GF_MIX_ABORT_EN
  input  logic                  abort,
`endif
  gf_mix_columns_seq_if.slave   bus
);

  localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int BW = 32 * NCOL;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_COL = CW'(NCOL - 1);

  logic [1:0]    state;
  logic [CW-1:0] col_cnt;
  logic [BW-1:0] blk_q;
  logic          mode_q;
  logic [BW-1:0] data_q;

  logic          abort_req;
  logic [31:0]   col_in;
  logic [31:0]   col_out;

`ifdef GF_MIX_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // GF(2^8) arithmetic
  // -------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
  endfunction

  // Byte r of a column lives at bits [31-8r -: 8].
  function automatic logic [31:0] mix_enc(input logic [31:0] c);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xtime(a[i]);
    end
    // 2*a_r ^ 3*a_{r+1} ^ a_{r+2} ^ a_{r+3}, with 3*a = xtime(a) ^ a
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = x2[i] ^ x2[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
    end
    return r;
  endfunction

  function automatic logic [31:0] mix_dec(input logic [31:0] c);
    logic [7:0]  a   [4];
    logic [7:0]  x2  [4];
    logic [7:0]  x4  [4];
    logic [7:0]  x8  [4];
    logic [7:0]  m09 [4];
    logic [7:0]  m0b [4];
    logic [7:0]  m0d [4];
    logic [7:0]  m0e [4];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]   = c[31-8*i -: 8];
      x2[i]  = xtime(a[i]);
      x4[i]  = xtime(x2[i]);
      x8[i]  = xtime(x4[i]);
      m09[i] = x8[i] ^ a[i];
      m0b[i] = x8[i] ^ x2[i] ^ a[i];
      m0d[i] = x8[i] ^ x4[i] ^ a[i];
      m0e[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = m0e[i] ^ m0b[(i+1)%4] ^ m0d[(i+2)%4] ^ m09[(i+3)%4];
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Column datapath: select the active column of the latched block and mix
  // it. Everything here depends only on registered state, so in-flight
  // blocks are immune to changes on data_in/mode after accept.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: give every always_comb output a default before any branch, so a
    // path that skips the assignment cannot infer a latch.
    col_in = '0;
    for (int c = 0; c < NCOL; c++) begin
      if (col_cnt == CW'(c)) begin
        col_in = blk_q[BW-1-32*c -: 32];
      end
    end
  end

  assign col_out = mode_q ? mix_dec(col_in) : mix_enc(col_in);

  // -------------------------------------------------------------------------
  // Control FSM and result register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      col_cnt <= '0;
      // NOTE: the block, mode and result registers are wide but are reset
      // anyway: data_out must read zero after reset and on abort.
      blk_q   <= '0;
      mode_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            blk_q   <= bus.data_in;
            mode_q  <= bus.mode;
            col_cnt <= '0;
            state   <= S_RUN;
          end
        end

        S_RUN: begin
          if (abort_req) begin
            state   <= S_IDLE;
            col_cnt <= '0;
            data_q  <= '0;
          end else begin
            for (int c = 0; c < NCOL; c++) begin
              if (col_cnt == CW'(c)) begin
                data_q[BW-1-32*c -: 32] <= col_out;
              end
            end
            // Counter stops on the last column instead of wrapping.
            if (col_cnt == LAST_COL) begin
              state <= S_DONE;
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          // abort outranks out_ready; result stays frozen until either.
          if (abort_req) begin
            state   <= S_IDLE;
            col_cnt <= '0;
            data_q  <= '0;
          end else if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state   <= S_IDLE;
          col_cnt <= '0;
        end
      endcase
    end
  end

  // Handshake outputs decode straight from the state register, so in_ready
  // only rises the cycle after the DONE -> IDLE edge.
  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state == S_RUN) || (state == S_DONE);
  assign bus.data_out  = data_q;

endmodule

// File: tb/tb_gf_mix_columns_seq.sv
// ---------------------------------------------------------------------------
// tb_gf_mix_columns_seq
//
// Exercises two instances of gf_mix_columns_seq (NCOL=4 and NCOL=1) against
// a reference model that multiplies each column by the AES (inverse) MixColumns
// matrix using a generic shift-and-add GF(2^8) multiply. Inputs change and
// outputs are sampled on the falling clock edge.
// Build with +define+GF_MIX_ABORT_EN to include the abort scenarios.
// ---------------------------------------------------------------------------
module tb_gf_mix_columns_seq;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  gf_mix_columns_seq_if #(.NCOL(4)) b4 ();
  gf_mix_columns_seq_if #(.NCOL(1)) b1 ();

`ifdef GF_MIX_ABORT_EN
  logic abort4;
  logic abort1;
`endif

  gf_mix_columns_seq #(.NCOL(4), .POLY(8'h1b)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef GF_MIX_ABORT_EN
    .abort (abort4),
`endif
    .bus   (b4)
  );

  gf_mix_columns_seq #(.NCOL(1), .POLY(8'h1b)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef GF_MIX_ABORT_EN
    .abort (abort1),
`endif
    .bus   (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input int ncol, input logic m, input logic [127:0] d);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   b;
    logic [31:0]  col;
    logic [127:0] res;
    if (m) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    res = '0;
    for (int c = 0; c < ncol; c++) begin
      col = d[32*(ncol-1-c) +: 32];
      for (int r = 0; r < 4; r++) a[r] = col[31-8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gmul(coef[k], a[(r+k)%4]);
        res[32*(ncol-1-c) + 24 - 8*r +: 8] = b;
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------- access
  task automatic drive_in(input int w, input logic v, input logic m, input logic [127:0] d);
    if (w == 4) begin
      b4.in_valid = v; b4.mode = m; b4.data_in = d;
    end else begin
      b1.in_valid = v; b1.mode = m; b1.data_in = d[31:0];
    end
  endtask

  task automatic set_ordy(input int w, input logic v);
    if (w == 4) b4.out_ready = v;
    else        b1.out_ready = v;
  endtask

  function automatic logic obs_iready(input int w);
    return (w == 4) ? b4.in_ready : b1.in_ready;
  endfunction

  function automatic logic obs_ovalid(input int w);
    return (w == 4) ? b4.out_valid : b1.out_valid;
  endfunction

  function automatic logic obs_busy(input int w);
    return (w == 4) ? b4.busy : b1.busy;
  endfunction

  function automatic logic [127:0] obs_dout(input int w);
    return (w == 4) ? b4.data_out : {96'h0, b1.data_out};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Wait (bounded) for in_ready at a falling edge; counts a timeout as a failure.
  task automatic wait_ready(input int w);
    int guard;
    guard = 0;
    while (obs_iready(w) !== 1'b1 && guard < 30) begin
      @(negedge clk); guard++;
    end
    if (guard >= 30) begin
      total++; bad++;
      $display("FAIL wait_ready dut%0d: in_ready stayed %b, wanted 1", w, obs_iready(w));
    end
  endtask

  // Accept one block, scramble the inputs, count edges until out_valid.
  // Leaves the caller at a falling edge with the result presented.
  task automatic start_and_wait(input int w, input logic m, input logic [127:0] d, output int lat);
    @(negedge clk);
    wait_ready(w);
    drive_in(w, 1'b1, m, d);
    @(posedge clk);
    @(negedge clk);
    drive_in(w, 1'b0, ~m, rand128());
    lat = 0;
    while (obs_ovalid(w) !== 1'b1 && lat < 30) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_blk(input int w, input logic m, input logic [127:0] d, input int delay,
                         output logic [127:0] got, output int lat);
    start_and_wait(w, m, d, lat);
    got = obs_dout(w);
    repeat (delay) @(negedge clk);
    set_ordy(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ordy(w, 1'b0);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int w = 1; w <= 4; w += 3) begin
      total++;
      if (obs_iready(w) !== 1'b1 || obs_ovalid(w) !== 1'b0 || obs_busy(w) !== 1'b0 || obs_dout(w) !== '0) begin
        bad++;
        $display("FAIL reset dut%0d: in_ready=%b out_valid=%b busy=%b data_out=%h, wanted 1 0 0 0",
                 w, obs_iready(w), obs_ovalid(w), obs_busy(w), obs_dout(w));
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (b4.in_ready !== 1'b1 || b4.busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: in_ready=%b busy=%b, wanted 1 0", b4.in_ready, b4.busy);
    end
  endtask

  task automatic test_known_vectors();
    logic [127:0] got;
    int lat;
    run_blk(4, 1'b0, 128'hdb135345_f20a225c_01010101_2d26314c, 0, got, lat);
    total++;
    if (got !== 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8) begin
      bad++; $display("FAIL enc4_vector: got %h want 8e4da1bc9fdc589d010101014d7ebdf8", got);
    end
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL enc4_latency: got %0d edges want 4", lat);
    end
    run_blk(4, 1'b1, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1, got, lat);
    total++;
    if (got !== 128'hdb135345_f20a225c_01010101_2d26314c) begin
      bad++; $display("FAIL dec4_vector: got %h want db135345f20a225c010101012d26314c", got);
    end
  endtask

  task automatic test_ncol1();
    logic [127:0] got;
    int lat;
    run_blk(1, 1'b0, {96'h0, 32'hd4d4d4d5}, 0, got, lat);
    total++;
    if (got[31:0] !== 32'hd5d5d7d6) begin
      bad++; $display("FAIL enc1_d4: got %h want d5d5d7d6", got[31:0]);
    end
    total++;
    if (lat !== 1) begin
      bad++; $display("FAIL enc1_latency: got %0d edges want 1", lat);
    end
    run_blk(1, 1'b0, {96'h0, 32'hc6c6c6c6}, 0, got, lat);
    total++;
    if (got[31:0] !== 32'hc6c6c6c6) begin
      bad++; $display("FAIL enc1_c6: got %h want c6c6c6c6", got[31:0]);
    end
  endtask

  task automatic test_random();
    logic [127:0] d, got, exp;
    logic m;
    int lat;
    for (int i = 0; i < 12; i++) begin
      int w;
      w = (i % 2 == 0) ? 4 : 1;
      d = rand128();
      if (w == 1) d = {96'h0, d[31:0]};
      m = 1'($urandom_range(0, 1));
      exp = model(w, m, d);
      run_blk(w, m, d, $urandom_range(0, 3), got, lat);
      total++;
      if (got !== exp || lat !== w) begin
        bad++;
        $display("FAIL random[%0d] dut%0d mode=%b: got %h lat %0d, want %h lat %0d",
                 i, w, m, got, lat, exp, w);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d, exp;
    int lat;
    d   = rand128();
    exp = model(4, 1'b0, d);
    start_and_wait(4, 1'b0, d, lat);
    // A competing block is offered while the result is stalled.
    drive_in(4, 1'b1, 1'b1, rand128());
    for (int i = 0; i < 10; i++) begin
      total++;
      if (b4.data_out !== exp || b4.in_ready !== 1'b0 || b4.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall[%0d]: data_out=%h in_ready=%b out_valid=%b, want %h 0 1",
                 i, b4.data_out, b4.in_ready, b4.out_valid, exp);
      end
      @(negedge clk);
    end
    drive_in(4, 1'b0, 1'b0, '0);
    set_ordy(4, 1'b1);
    total++;
    if (b4.in_ready !== 1'b0) begin
      bad++; $display("FAIL release_same_cycle: in_ready=%b want 0", b4.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    set_ordy(4, 1'b0);
    total++;
    if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0 || b4.busy !== 1'b0) begin
      bad++;
      $display("FAIL release_next_cycle: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
               b4.in_ready, b4.out_valid, b4.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] blks  [4];
    logic         modes [4];
    logic [127:0] expq  [$];
    int           acc   [$];
    logic [127:0] e;
    int nxt, got, cyc;
    bit pend;
    for (int k = 0; k < 4; k++) begin
      blks[k]  = rand128();
      modes[k] = 1'($urandom_range(0, 1));
    end
    nxt = 0; got = 0; cyc = 0; pend = 0;
    @(negedge clk);
    set_ordy(4, 1'b1);
    drive_in(4, 1'b1, modes[0], blks[0]);
    while (got < 4 && cyc < 80) begin
      if (pend) begin
        pend = 0;
        nxt++;
        if (nxt < 4) drive_in(4, 1'b1, modes[nxt], blks[nxt]);
        else         drive_in(4, 1'b0, 1'b0, '0);
      end
      if (b4.out_valid === 1'b1) begin
        total++;
        e = (expq.size() > 0) ? expq.pop_front() : 128'hx;
        if (b4.data_out !== e) begin
          bad++; $display("FAIL b2b_data[%0d]: got %h want %h", got, b4.data_out, e);
        end
        got++;
      end
      if (b4.in_ready === 1'b1 && b4.in_valid === 1'b1 && nxt < 4) begin
        acc.push_back(cyc);
        expq.push_back(model(4, modes[nxt], blks[nxt]));
        pend = 1;
      end
      @(negedge clk);
      cyc++;
    end
    set_ordy(4, 1'b0);
    drive_in(4, 1'b0, 1'b0, '0);
    total++;
    if (got != 4 || acc.size() != 4) begin
      bad++; $display("FAIL b2b_timeout: results %0d accepts %0d, want 4 4", got, acc.size());
    end else begin
      for (int k = 1; k < 4; k++) begin
        total++;
        if (acc[k] - acc[k-1] != 6) begin
          bad++; $display("FAIL b2b_spacing[%0d]: got %0d cycles want 6", k, acc[k] - acc[k-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] d, got;
    int lat;
    @(negedge clk);
    wait_ready(4);
    drive_in(4, 1'b1, 1'b0, rand128());
    @(posedge clk);               // accept edge, col_cnt = 0
    @(negedge clk);
    drive_in(4, 1'b0, 1'b0, '0);
    @(posedge clk);               // column 0 done, col_cnt = 1
    @(posedge clk);               // column 1 done, col_cnt = 2
    #1;
    total++;
    if (b4.busy !== 1'b1 || b4.data_out === '0) begin
      bad++; $display("FAIL pre_abort_state: busy=%b data_out=%h, want 1 and partial result", b4.busy, b4.data_out);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (b4.out_valid !== 1'b0 || b4.data_out !== '0 || b4.in_ready !== 1'b1 || b4.busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: out_valid=%b data_out=%h in_ready=%b busy=%b, want 0 0 1 0",
               b4.out_valid, b4.data_out, b4.in_ready, b4.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    d = rand128();
    run_blk(4, 1'b1, d, 0, got, lat);
    total++;
    if (got !== model(4, 1'b1, d) || lat !== 4) begin
      bad++; $display("FAIL after_reset_block: got %h lat %0d want %h lat 4", got, lat, model(4, 1'b1, d));
    end
  endtask

`ifdef GF_MIX_ABORT_EN
  task automatic test_abort();
    logic [127:0] got, d;
    int lat;
    // abort together with out_ready in DONE
    start_and_wait(1, 1'b0, {96'h0, $urandom}, lat);
    abort1 = 1'b1;
    set_ordy(1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    abort1 = 1'b0;
    set_ordy(1, 1'b0);
    total++;
    if (b1.out_valid !== 1'b0 || b1.data_out !== 32'h0 || b1.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_done: out_valid=%b data_out=%h in_ready=%b, want 0 0 1",
               b1.out_valid, b1.data_out, b1.in_ready);
    end
    run_blk(1, 1'b0, {96'h0, 32'hdb135345}, 0, got, lat);
    total++;
    if (got[31:0] !== 32'h8e4da1bc) begin
      bad++; $display("FAIL after_abort_block: got %h want 8e4da1bc", got[31:0]);
    end
    // abort mid-RUN discards a partly written result
    @(negedge clk);
    wait_ready(4);
    drive_in(4, 1'b1, 1'b0, rand128());
    @(posedge clk);
    @(negedge clk);
    drive_in(4, 1'b0, 1'b0, '0);
    @(negedge clk);
    abort4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort4 = 1'b0;
    total++;
    if (b4.busy !== 1'b0 || b4.data_out !== '0 || b4.in_ready !== 1'b1) begin
      bad++; $display("FAIL abort_run: busy=%b data_out=%h in_ready=%b, want 0 0 1", b4.busy, b4.data_out, b4.in_ready);
    end
    // abort in IDLE is ignored and the block is still accepted
    d = {96'h0, $urandom};
    @(negedge clk);
    wait_ready(1);
    drive_in(1, 1'b1, 1'b1, d);
    abort1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort1 = 1'b0;
    drive_in(1, 1'b0, 1'b0, '0);
    total++;
    if (b1.busy !== 1'b1) begin
      bad++; $display("FAIL abort_idle_accept: busy=%b want 1", b1.busy);
    end
    @(negedge clk);
    total++;
    if (b1.out_valid !== 1'b1 || b1.data_out !== model(1, 1'b1, d)) begin
      bad++; $display("FAIL abort_idle_result: out_valid=%b data_out=%h want 1 %h",
                      b1.out_valid, b1.data_out, model(1, 1'b1, d));
    end
    set_ordy(1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ordy(1, 1'b0);
  endtask
`endif

  // ---------------------------------------------------------------- main
  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive_in(4, 1'b0, 1'b0, '0);
    drive_in(1, 1'b0, 1'b0, '0);
    set_ordy(4, 1'b0);
    set_ordy(1, 1'b0);
`ifdef GF_MIX_ABORT_EN
    abort4 = 1'b0;
    abort1 = 1'b0;
`endif
    test_reset();
    test_known_vectors();
    test_ncol1();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
`ifdef GF_MIX_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
